// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command becomes one
// cyc/stb cycle, ended by ack, err or timeout, and is answered by a valid/ready response.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cyc_n, we_n;
  logic [3:0]       sel_n;
  logic [31:0]      adr_n, dat_n, rsp_dat_n;
  logic             rsp_valid_n, rsp_err_n, rsp_timeout_n;
  logic             timeout_hit;

  // cmd_ready is held low while reset is asserted so every output reads 0 in reset.
  assign cmd_ready   = (state == IDLE) && !wb_rst_i;
  assign busy        = (state != IDLE);
  assign wbm_stb_o   = wbm_cyc_o;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == LAST_CNT);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wbm_cyc_o   <= cyc_n;
      wbm_we_o    <= we_n;
      wbm_sel_o   <= sel_n;
      wbm_adr_o   <= adr_n;
      wbm_dat_o   <= dat_n;
      rsp_valid   <= rsp_valid_n;
      rsp_dat     <= rsp_dat_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    cyc_n         = wbm_cyc_o;
    we_n          = wbm_we_o;
    sel_n         = wbm_sel_o;
    adr_n         = wbm_adr_o;
    dat_n         = wbm_dat_o;
    rsp_valid_n   = rsp_valid;
    rsp_dat_n     = rsp_dat;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          cyc_n   = 1'b1;
          we_n    = cmd_we;
          sel_n   = cmd_sel;
          adr_n   = cmd_adr;
          dat_n   = cmd_dat;
          cnt_n   = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        cnt_n = cnt + 1'b1;
        // err outranks ack, and a real ack in the final cycle outranks the timeout.
        if (wbm_err_i || wbm_ack_i || timeout_hit) begin
          cyc_n         = 1'b0;
          we_n          = 1'b0;
          sel_n         = '0;
          rsp_valid_n   = 1'b1;
          rsp_err_n     = wbm_err_i || !wbm_ack_i;
          rsp_timeout_n = !wbm_err_i && !wbm_ack_i;
          rsp_dat_n     = (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : 32'h0;
          state_n       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n   = 1'b0;
          rsp_err_n     = 1'b0;
          rsp_timeout_n = 1'b0;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master (timeout shortened to 8 cycles).
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i, busy;

  int n_checks = 0;
  int n_fail   = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    tick(); tick();
    n_checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cyc got=%b%b exp=00", wbm_cyc_o, wbm_stb_o); end
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_busy got=%b%b exp=00", rsp_valid, busy); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    rst = 1'b0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    wbm_dat_i = 32'hFFFF_FFFF;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_ready got=%b exp=1", cmd_ready); end
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_cyc%0d got=%b%b%b exp=111", i, wbm_cyc_o, wbm_stb_o, wbm_we_o); end
      n_checks++; if (wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'hDEAD_BEEF || wbm_sel_o !== 4'hF) begin n_fail++; $display("[TB] FAIL wr_fields%0d got=%h/%h/%h exp=30000004/deadbeef/f", i, wbm_adr_o, wbm_dat_o, wbm_sel_o); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_early_rsp%0d got=%b exp=0", i, rsp_valid); end
      if (i == 1) wbm_ack_i = 1'b1;
      tick();
    end
    wbm_ack_i = 1'b0;
    n_checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'h0) begin n_fail++; $display("[TB] FAIL wr_release got=%b%b%b%h exp=0000", wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_rsp got=%b%b%b exp=100", rsp_valid, rsp_err, rsp_timeout); end
    n_checks++; if (rsp_dat !== 32'h0) begin n_fail++; $display("[TB] FAIL wr_rsp_dat got=%h exp=00000000", rsp_dat); end
    handshake();
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_done got=%b%b%b exp=010", rsp_valid, cmd_ready, busy); end
  endtask

  task automatic test_read();
    issue(1'b0, 32'h3000_0000, 32'h0);
    n_checks++; if (wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_cyc got=%b%b exp=10", wbm_cyc_o, wbm_we_o); end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
    tick();
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_hold%0d got=%b/%h/%b exp=1/12345678/0", i, rsp_valid, rsp_dat, rsp_err); end
      n_checks++; if (cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_resp_state%0d got=%b%b exp=00", i, cmd_ready, wbm_cyc_o); end
      cmd_valid = (i == 2);
      tick();
    end
    cmd_valid = 1'b0;
    handshake();
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_done got=%b%b%b exp=010", rsp_valid, cmd_ready, wbm_cyc_o); end
  endtask

  task automatic test_timeout();
    int stb_cycles = 0;
    wbm_dat_i = 32'h5555_AAAA;
    issue(1'b0, 32'h3000_0008, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (wbm_stb_o) stb_cycles++;
      if (rsp_valid) break;
      tick();
    end
    n_checks++; if (stb_cycles != 8) begin n_fail++; $display("[TB] FAIL to_stb_cycles got=%0d exp=8", stb_cycles); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_dat !== 32'h0) begin n_fail++; $display("[TB] FAIL to_rsp got=%b%b%b/%h exp=111/00000000", rsp_valid, rsp_err, rsp_timeout, rsp_dat); end
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_dat !== 32'h0 || wbm_cyc_o !== 1'b0) begin n_fail++; $display("[TB] FAIL to_late_ack got=%b%b%b/%h/%b exp=111/00000000/0", rsp_valid, rsp_err, rsp_timeout, rsp_dat, wbm_cyc_o); end
    handshake();
    n_checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL to_clear got=%b%b%b exp=001", rsp_err, rsp_timeout, cmd_ready); end
  endtask

  task automatic test_ack_err();
    issue(1'b0, 32'h3000_000C, 32'h0);
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'hAAAA_5555;
    tick();
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_dat !== 32'h0) begin n_fail++; $display("[TB] FAIL ackerr_rsp got=%b%b%b/%h exp=110/00000000", rsp_valid, rsp_err, rsp_timeout, rsp_dat); end
    handshake();
    issue(1'b0, 32'h3000_0010, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lastack_cycle8 got=%b%b exp=10", wbm_cyc_o, rsp_valid); end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
    tick();
    wbm_ack_i = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_dat !== 32'hCAFE_F00D) begin n_fail++; $display("[TB] FAIL lastack_rsp got=%b%b%b/%h exp=100/cafef00d", rsp_valid, rsp_err, rsp_timeout, rsp_dat); end
    handshake();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 32'h3000_0020, 32'h0BAD_F00D);
    n_checks++; if (wbm_cyc_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_pre got=%b exp=1", wbm_cyc_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_async got=%b%b exp=00", wbm_cyc_o, wbm_stb_o); end
    wbm_ack_i = 1'b1;
    tick(); tick();
    rst = 1'b0; wbm_ack_i = 1'b0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_after got=%b%b%b%b exp=1000", cmd_ready, busy, rsp_valid, wbm_cyc_o); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_norsp got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs [4];
    logic [31:0] got  [4];
    int          acc_at [4];
    int          na = 0, nr = 0, cyc_idx = 0;
    logic        acc_now, rsp_now;
    adrs[0] = 32'h3000_0100; adrs[1] = 32'h3000_0104; adrs[2] = 32'h3000_0200; adrs[3] = 32'h3000_0FFC;
    cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = adrs[0]; cmd_valid = 1'b1; rsp_ready = 1'b1;
    while (nr < 4 && cyc_idx < 40) begin
      wbm_ack_i = wbm_cyc_o;
      wbm_dat_i = wbm_adr_o ^ 32'h5A5A_5A5A;
      acc_now = cmd_valid && cmd_ready;
      rsp_now = rsp_valid && rsp_ready;
      if (rsp_now) begin got[nr] = rsp_dat; nr++; end
      if (acc_now) begin acc_at[na] = cyc_idx; na++; end
      tick();
      cyc_idx++;
      if (acc_now) begin
        if (na < 4) cmd_adr = adrs[na];
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; wbm_ack_i = 1'b0;
    n_checks++; if (nr != 4 || na != 4) begin n_fail++; $display("[TB] FAIL b2b_count got acc=%0d rsp=%0d exp=4/4", na, nr); end
    for (int i = 0; i < 4; i++) begin
      if (i < nr) begin
        n_checks++; if (got[i] !== (adrs[i] ^ 32'h5A5A_5A5A)) begin n_fail++; $display("[TB] FAIL b2b_dat%0d got=%h exp=%h", i, got[i], adrs[i] ^ 32'h5A5A_5A5A); end
      end
      if (i > 0 && i < na) begin
        n_checks++; if (acc_at[i] - acc_at[i-1] != 3) begin n_fail++; $display("[TB] FAIL b2b_interval%0d got=%0d exp=3", i, acc_at[i] - acc_at[i-1]); end
      end
    end
    tick();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle got=%b%b%b exp=000", busy, rsp_valid, wbm_cyc_o); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_err();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
